// File: rtl/ram_port_arbiter.sv
// Two-port arbiter sharing one block RAM port between I-cache (port 0) and D-cache (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin grant; otherwise port 1 has fixed priority.
module ram_port_arbiter #(
  parameter int unsigned ADDR_SIZE       = 24,
  parameter int unsigned BLOCK_BITS      = 128,
  parameter int unsigned MIN_BUSY_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_r,
  input  logic                  p0_req_w,
  input  logic [ADDR_SIZE-1:0]  p0_addr,
  input  logic [BLOCK_BITS-1:0] p0_wdata,
  output logic [BLOCK_BITS-1:0] p0_rdata,
  output logic                  p0_done,
  input  logic                  p1_req_r,
  input  logic                  p1_req_w,
  input  logic [ADDR_SIZE-1:0]  p1_addr,
  input  logic [BLOCK_BITS-1:0] p1_wdata,
  output logic [BLOCK_BITS-1:0] p1_rdata,
  output logic                  p1_done,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic                  mem_r,
  output logic                  mem_w,
  output logic [BLOCK_BITS-1:0] mem_wdata,
  output logic                  mem_oe,
  input  logic [BLOCK_BITS-1:0] mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [2:0] {
    StIdle, StIssue, StStrobe, StWaitBusy, StWaitDone, StResp
  } state_e;

  localparam int unsigned CntW = $clog2(MIN_BUSY_CYCLES + 2);
  localparam logic [CntW-1:0] CntMax = CntW'(MIN_BUSY_CYCLES);

  state_e                state_q, state_d;
  logic                  ready_q;
  logic                  gnt_q, gnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
  logic                  mem_r_q, mem_r_d;
  logic                  mem_w_q, mem_w_d;
  logic                  oe_q, oe_d;
  logic                  p0_done_q, p0_done_d;
  logic                  p1_done_q, p1_done_d;
  logic [BLOCK_BITS-1:0] p0_rdata_q, p0_rdata_d;
  logic [BLOCK_BITS-1:0] p1_rdata_q, p1_rdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic p0_valid, p1_valid, gnt_sel;

  assign p0_valid = p0_req_r | p0_req_w;
  assign p1_valid = p1_req_r | p1_req_w;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_q names the port preferred on the next simultaneous request.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_sel = p1_valid;
    if (p0_valid && p1_valid) begin
      gnt_sel = ptr_q;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StResp) begin
      ptr_d = ~gnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign gnt_sel = p1_valid;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_r_d    = mem_r_q;
    mem_w_d    = mem_w_q;
    oe_d       = oe_q;
    p0_done_d  = 1'b0;
    p1_done_d  = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      StIdle: begin
        if ((p0_valid || p1_valid) && ready_q) begin
          gnt_d  = gnt_sel;
          wr_d   = gnt_sel ? p1_req_w : p0_req_w;
          addr_d = gnt_sel ? p1_addr : p0_addr;
          if (wr_d) begin
            wdata_d = gnt_sel ? p1_wdata : p0_wdata;
          end
          // Address/data and bus enable are visible during ISSUE, ahead of the strobe.
          oe_d    = wr_d;
          state_d = StIssue;
        end
      end
      StIssue: begin
        mem_r_d = ~wr_q;
        mem_w_d = wr_q;
        state_d = StStrobe;
      end
      StStrobe: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!ready_q) begin
          state_d = StWaitDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d >= CntMax) begin
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        if (ready_q) begin
          if (!wr_q) begin
            if (gnt_q) begin
              p1_rdata_d = mem_rdata;
            end else begin
              p0_rdata_d = mem_rdata;
            end
          end
          mem_r_d   = 1'b0;
          mem_w_d   = 1'b0;
          oe_d      = 1'b0;
          p0_done_d = ~gnt_q;
          p1_done_d = gnt_q;
          state_d   = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      gnt_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_r_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      oe_q       <= 1'b0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= mem_ready;
      gnt_q      <= gnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_r_q    <= mem_r_d;
      mem_w_q    <= mem_w_d;
      oe_q       <= oe_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_r     = mem_r_q;
  assign mem_w     = mem_w_q;
  assign mem_oe    = oe_q;
  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a simple edge-triggered RAM model.
module tb_ram_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         p0_req_r, p0_req_w, p1_req_r, p1_req_w;
  logic [23:0]  p0_addr, p1_addr;
  logic [127:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic         p0_done, p1_done;
  logic [23:0]  mem_addr;
  logic         mem_r, mem_w, mem_oe;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit           port;
    bit           rd;
    logic [127:0] data;
  } exp_t;
  exp_t sb[$];

  localparam logic [127:0] D10 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] D20 = 128'h1234_5678_9ABC_DEF0_0F0F_F0F0_AAAA_5555;
  localparam logic [127:0] D30 = 128'hCAFE_F00D_0000_0000_1111_1111_2222_3333;

  ram_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req_r  (p0_req_r),
    .p0_req_w  (p0_req_w),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_rdata  (p0_rdata),
    .p0_done   (p0_done),
    .p1_req_r  (p1_req_r),
    .p1_req_w  (p1_req_w),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_rdata  (p1_rdata),
    .p1_done   (p1_done),
    .mem_addr  (mem_addr),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_wdata (mem_wdata),
    .mem_oe    (mem_oe),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // RAM model: acts on the rising edge of a strobe, busy for ram_lat cycles.
  logic [127:0] ram [int unsigned];
  int   ram_lat  = 3;
  int   busy_cnt = 0;
  logic prev_r   = 1'b0;
  logic prev_w   = 1'b0;
  logic pend_rd  = 1'b0;
  logic [23:0] pend_a = '0;

  always @(posedge clk) begin
    prev_r <= mem_r;
    prev_w <= mem_w;
    if ((mem_r && !prev_r) || (mem_w && !prev_w)) begin
      if (mem_w) ram[32'(mem_addr)] = mem_wdata;
      if (ram_lat == 0) begin
        if (mem_r) mem_rdata <= ram[32'(mem_addr)];
      end else begin
        mem_ready <= 1'b0;
        busy_cnt  <= ram_lat;
        pend_rd   <= mem_r;
        pend_a    <= mem_addr;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        mem_ready <= 1'b1;
        if (pend_rd) mem_rdata <= ram[32'(pend_a)];
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit port, input bit rd, input logic [127:0] data);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive(input bit port, input bit r, input bit w, input logic [23:0] a,
                       input logic [127:0] d);
    if (!port) begin
      p0_req_r = r; p0_req_w = w; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req_r = r; p1_req_w = w; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic drop(input bit port);
    if (!port) begin
      p0_req_r = 1'b0; p0_req_w = 1'b0;
    end else begin
      p1_req_r = 1'b0; p1_req_w = 1'b0;
    end
  endtask

  task automatic wait_done(input bit port);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = port ? p1_done : p0_done;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout port%0d: got no done in 200 cycles expected done=1", port);
    end
    drop(port);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on each done and watches strobe/bus-enable shape.
  int   low_cnt  = 100;
  logic prev_mw  = 1'b0;
  logic prev_oe  = 1'b0;
  logic saw_mem_r = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    logic strobe;
    if (!rst) begin
      if (p0_done && p1_done) begin
        check("done_overlap", {p0_done, p1_done}, 128'b01);
      end else if (p0_done || p1_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {p0_done, p1_done}, 128'b00);
        end else begin
          e = sb.pop_front();
          check("done_port", 128'(p1_done), 128'(e.port));
          if (e.rd) check("rdata", p1_done ? p1_rdata : p0_rdata, e.data);
        end
      end
      strobe = mem_r | mem_w;
      if (strobe && low_cnt < 100 && low_cnt > 0 && (prev_mw | mem_r | mem_w) && low_cnt != 0)
        check("strobe_low_gap", 128'(low_cnt >= 2), 128'b1);
      if (mem_w && !prev_mw) check("oe_before_mem_w", 128'(prev_oe), 128'b1);
      if (!mem_w && prev_mw) check("oe_drop_with_mem_w", 128'(mem_oe), 128'b0);
      if (mem_r) saw_mem_r = 1'b1;
      low_cnt = strobe ? 0 : ((low_cnt < 99) ? low_cnt + 1 : 99);
      prev_mw = mem_w;
      prev_oe = mem_oe;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300us");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  up;
    ram[32'h10] = D10;
    ram[32'h20] = '0;
    ram[32'h30] = '0;
    ram[32'h1]  = 128'h1;
    ram[32'h2]  = 128'h22;
    ram[32'h3]  = 128'h333;
    ram[32'h40] = 128'h4040_4040;
    ram[32'h41] = 128'h4141_4141_4141;
    ram[32'h50] = 128'h5050_AAAA;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    rst = 1'b1;
    cycles(3);

    check("rst_mem_r", 128'(mem_r), 0);
    check("rst_mem_w", 128'(mem_w), 0);
    check("rst_mem_oe", 128'(mem_oe), 0);
    check("rst_mem_addr", 128'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_p0_done", 128'(p0_done), 0);
    check("rst_p1_done", 128'(p1_done), 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    rst = 1'b0;
    cycles(3);

    // Single read on port 0; strobe rises two cycles after the grant edge.
    push(0, 1, D10);
    drive(0, 1, 0, 24'h10, '0);
    lat = 0;
    up  = 1'b0;
    for (int i = 0; i < 10 && !up; i++) begin
      @(posedge clk);
      #1;
      lat++;
      up = mem_r;
    end
    check("mem_r_latency", 128'(lat), 2);
    check("read_addr", 128'(mem_addr), 128'h10);
    wait_done(0);

    // Port 1 write then read back; the write leaves p1_rdata untouched.
    push(1, 0, '0);
    drive(1, 0, 1, 24'h20, D20);
    wait_done(1);
    check("write_keeps_rdata", p1_rdata, 0);
    push(1, 1, D20);
    drive(1, 1, 0, 24'h20, '0);
    wait_done(1);

    // Back-to-back port 0 reads.
    for (int k = 1; k <= 3; k++) begin
      push(0, 1, ram[k]);
      drive(0, 1, 0, 24'(k), '0);
      wait_done(0);
    end

    // Read+write on port 1 is a write.
    saw_mem_r = 1'b0;
    push(1, 0, '0);
    drive(1, 1, 1, 24'h30, D30);
    wait_done(1);
    check("rw_no_mem_r", 128'(saw_mem_r), 0);
    push(0, 1, D30);
    drive(0, 1, 0, 24'h30, '0);
    wait_done(0);

    // RAM never drops ready: the busy-wait timeout path.
    ram_lat = 0;
    push(0, 1, 128'h4141_4141_4141);
    drive(0, 1, 0, 24'h41, '0);
    wait_done(0);
    ram_lat = 8;
    cycles(2);

    // Reset during WAIT_DONE.
    drive(0, 1, 0, 24'h50, '0);
    up = 1'b0;
    for (int i = 0; i < 20 && !up; i++) begin
      @(posedge clk);
      #1;
      up = mem_r;
    end
    check("midop_strobe_seen", 128'(up), 1);
    cycles(4);
    rst = 1'b1;
    cycles(1);
    check("midop_mem_r", 128'(mem_r), 0);
    check("midop_mem_oe", 128'(mem_oe), 0);
    check("midop_p0_done", 128'(p0_done), 0);
    check("midop_p1_done", 128'(p1_done), 0);
    rst = 1'b0;
    drop(0);
    ram_lat = 3;
    up = 1'b0;
    for (int i = 0; i < 30 && !up; i++) begin
      @(posedge clk);
      #1;
      up = mem_ready;
    end
    cycles(2);

    // Contention straight after reset.
`ifdef ARB_ROUND_ROBIN_EN
    push(0, 1, 128'h4040_4040);
    push(1, 1, 128'h4141_4141_4141);
`else
    push(1, 1, 128'h4141_4141_4141);
    push(0, 1, 128'h4040_4040);
`endif
    drive(0, 1, 0, 24'h40, '0);
    drive(1, 1, 0, 24'h41, '0);
    fork
      wait_done(0);
      wait_done(1);
    join

    push(0, 1, 128'h5050_AAAA);
    drive(0, 1, 0, 24'h50, '0);
    wait_done(0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) cycles(1);
    check("scoreboard_empty", 128'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
